// File: rtl/dm_bank_if.sv
// -----------------------------------------------------------------------------
// dm_bank_if
//   Request/response bundle for the dm_bank data memory.
//   Optional macro: DM_BANK_PARITY_EN adds the inj_par_err request input.
//
//   Request  (master -> slave): req_valid, req_we, req_addr, req_sel, req_wdata
//                                [inj_par_err when DM_BANK_PARITY_EN]
//   Request  (slave -> master): req_ready
//   Response (slave -> master): rsp_valid, rsp_rdata, rsp_err
//   Status   (slave -> master): busy_init
// -----------------------------------------------------------------------------
interface dm_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NUM_LANES = DATA_W / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [NUM_LANES-1:0] req_sel;
  logic [DATA_W-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 rsp_err;
  logic                 busy_init;
`ifdef DM_BANK_PARITY_EN
  logic                 inj_par_err;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, inj_par_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_init
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, inj_par_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_init
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_init
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_init
  );
`endif

endinterface

// File: rtl/dm_bank.sv
// -----------------------------------------------------------------------------
// dm_bank
//   Byte-lane data memory for the MEM stage. Valid/ready request port with no
//   backpressure once initialised, fixed-latency (RD_LAT) in-order responses.
//   After reset the array is swept to zero, one word per cycle, for DEPTH
//   cycles; requests are refused (req_ready=0, busy_init=1) meanwhile.
//   Requests with address bits above the word index set, or with an empty
//   strobe, answer with rsp_err=1 and leave the array untouched.
//
//   Optional macro: DM_BANK_PARITY_EN
//     Stores one even-parity bit per byte lane. Reads recheck the selected
//     lanes and flag rsp_err on mismatch while still returning the data.
//     bus.inj_par_err high on a write inverts the stored parity of the
//     written lanes (fault injection).
//
//   Parameters
//     DATA_W  data width, multiple of 8
//     ADDR_W  byte-address width
//     DEPTH   words, power of 2
//     RD_LAT  response latency in cycles, 1..4
//
//   Ports
//     clk  clock, all state on the rising edge
//     rst  synchronous active-high reset
//     bus  dm_bank_if.slave: request, response and busy_init signals
// -----------------------------------------------------------------------------
module dm_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  dm_bank_if.slave   bus
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int LSB       = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int HI        = LSB + IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Sweep / run controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only reset leaves RUN.
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_init;
  logic run_ready;

  assign in_init       = (state_q == ST_INIT);
  assign run_ready     = (state_q == ST_RUN);
  assign bus.req_ready = run_ready;
  assign bus.busy_init = in_init;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] req_idx;
  logic             range_err;
  logic             strobe_err;
  logic             req_err;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic             sweep_we;
  logic             par_inj;

  assign req_idx    = bus.req_addr[LSB +: IDX_W];
  // Anything above the word index is out of range; the shift also covers
  // ADDR_W == HI where no upper bits exist.
  assign range_err  = ((bus.req_addr >> HI) != '0);
  assign strobe_err = (bus.req_sel == '0);
  assign req_err    = range_err | strobe_err;

  // rst is sampled at the same edge, so an accept coinciding with reset is void.
  assign accept   = bus.req_valid & run_ready & ~rst;
  assign wr_en    = accept & bus.req_we & ~req_err;
  assign rd_en    = accept & ~bus.req_we & ~req_err;
  assign sweep_we = in_init & ~rst;

`ifdef DM_BANK_PARITY_EN
  assign par_inj = bus.inj_par_err;
`else
  assign par_inj = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Byte-lane storage: one inferred RAM per lane, registered read
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][7:0] rd_lane;
  logic [NUM_LANES-1:0]      par_bad;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0]       mem_q [DEPTH];
      logic [7:0]       rd_q;
      logic             lane_we;
      logic [IDX_W-1:0] lane_addr;
      logic [7:0]       lane_wd;

      assign lane_we   = sweep_we | (wr_en & bus.req_sel[gi]);
      assign lane_addr = in_init ? cnt_q : req_idx;
      assign lane_wd   = in_init ? 8'h00 : bus.req_wdata[gi*8 +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem_q[lane_addr] <= lane_wd;
        end
        if (rd_en) begin
          rd_q <= mem_q[req_idx];
        end
      end

      assign rd_lane[gi] = rd_q;

`ifdef DM_BANK_PARITY_EN
      logic par_mem_q [DEPTH];
      logic par_rd_q;
      logic par_wd;

      // Even parity: stored bit makes the 9-bit group XOR to zero.
      assign par_wd = in_init ? 1'b0 : ((^lane_wd) ^ par_inj);

      always_ff @(posedge clk) begin
        if (lane_we) begin
          par_mem_q[lane_addr] <= par_wd;
        end
        if (rd_en) begin
          par_rd_q <= par_mem_q[req_idx];
        end
      end

      assign par_bad[gi] = (^rd_q) ^ par_rd_q;
`else
      assign par_bad[gi] = 1'b0;
`endif
    end
  endgenerate

  // par_inj only feeds the parity arrays; keep it referenced in both builds.
  logic par_inj_unused;
  assign par_inj_unused = par_inj;

  // ---------------------------------------------------------------------------
  // Stage 0: request attributes aligned with the registered array read
  // ---------------------------------------------------------------------------
  logic                 s0_valid_q;
  logic                 s0_err_q;
  logic                 s0_rd_q;
  logic [NUM_LANES-1:0] s0_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_rd_q    <= 1'b0;
      s0_sel_q   <= '0;
    end else begin
      s0_valid_q <= accept;
      s0_err_q   <= accept & req_err;
      s0_rd_q    <= rd_en;
      s0_sel_q   <= rd_en ? bus.req_sel : '0;
    end
  end

  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  // Unselected lanes, writes, errors and idle slots all return zero data
  // because s0_sel_q is cleared for everything except good reads.
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_mask
      assign rsp0_data[gi*8 +: 8] = s0_sel_q[gi] ? rd_lane[gi] : 8'h00;
    end
  endgenerate

  assign rsp0_err = s0_err_q | (s0_rd_q & (|(par_bad & s0_sel_q)));

  // ---------------------------------------------------------------------------
  // Response shift pipe: RD_LAT registered stages after the array read
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pe_q;
  logic [DATA_W-1:0] pd_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pd_q[k] <= '0;
      end
    end else begin
      pv_q[0] <= s0_valid_q;
      pe_q[0] <= rsp0_err;
      pd_q[0] <= rsp0_data;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pe_q[k] <= pe_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
    end
  end

  assign bus.rsp_valid = pv_q[RD_LAT-1];
  assign bus.rsp_err   = pe_q[RD_LAT-1];
  assign bus.rsp_rdata = pd_q[RD_LAT-1];

endmodule

// File: tb/tb_dm_bank.sv
// -----------------------------------------------------------------------------
// tb_dm_bank
//   Directed bench for dm_bank with DEPTH=16, RD_LAT=3. Every driven cycle
//   carries the hand-computed response expected RD_LAT cycles later; each
//   cycle compares rsp_valid/rsp_rdata/rsp_err against that expectation.
// -----------------------------------------------------------------------------
module tb_dm_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 3;

  logic clk;
  logic rst;

  dm_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dm_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Expected-response delay line, filled with hand-written values.
  logic        ev [RD_LAT];
  logic [31:0] ed [RD_LAT];
  logic        ee [RD_LAT];
  string       et [RD_LAT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive a request (or idle), clock it, compare the response due now.
  task automatic cyc(input string tag, input logic v, input logic we,
                     input logic [31:0] a, input logic [3:0] sel,
                     input logic [31:0] wd, input logic inj,
                     input logic [31:0] exp_d, input logic exp_e);
    logic        cv;
    logic [31:0] cd;
    logic        ce;
    string       ct;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_sel   = sel;
    bus.req_wdata = wd;
`ifdef DM_BANK_PARITY_EN
    bus.inj_par_err = inj;
`endif
    @(posedge clk);
    #1;
    cycle++;
    cv = ev[RD_LAT-1];
    cd = ed[RD_LAT-1];
    ce = ee[RD_LAT-1];
    ct = et[RD_LAT-1];
    for (int j = RD_LAT - 1; j > 0; j--) begin
      ev[j] = ev[j-1];
      ed[j] = ed[j-1];
      ee[j] = ee[j-1];
      et[j] = et[j-1];
    end
    ev[0] = v;
    ed[0] = exp_d;
    ee[0] = exp_e;
    et[0] = tag;
    if (rst) begin
      // Reset drops everything in flight.
      for (int j = 0; j < RD_LAT; j++) begin
        ev[j] = 1'b0;
        ed[j] = '0;
        ee[j] = 1'b0;
        et[j] = "none";
      end
      cv = 1'b0;
      cd = '0;
      ce = 1'b0;
      ct = "rst";
    end
    if (!cv) begin
      cd = '0;
      ce = 1'b0;
      ct = "idle";
    end
    check($sformatf("%s_valid@%0d", ct, cycle), {31'b0, bus.rsp_valid}, {31'b0, cv});
    check($sformatf("%s_rdata@%0d", ct, cycle), bus.rsp_rdata, cd);
    check($sformatf("%s_err@%0d", ct, cycle), {31'b0, bus.rsp_err}, {31'b0, ce});
    $display("cyc %0d req=%s v=%0b we=%0b addr=%h sel=%b | rsp v=%0b d=%h e=%0b",
             cycle, tag, v, we, a, sel, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc("idle", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] sel,
                    input logic [31:0] wd, input logic inj, input logic exp_e);
    cyc(tag, 1'b1, 1'b1, a, sel, wd, inj, 32'h0, exp_e);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] sel,
                    input logic [31:0] exp_d, input logic exp_e);
    cyc(tag, 1'b1, 1'b0, a, sel, 32'h0, 1'b0, exp_d, exp_e);
  endtask

  // Expects to start in the first cycle after rst falls.
  task automatic wait_init();
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("init_busy%0d", i), {31'b0, bus.busy_init}, 32'd1);
      check($sformatf("init_ready%0d", i), {31'b0, bus.req_ready}, 32'd0);
      idle(1);
    end
    check("run_ready", {31'b0, bus.req_ready}, 32'd1);
    check("run_busy", {31'b0, bus.busy_init}, 32'd0);
  endtask

  initial begin
    for (int j = 0; j < RD_LAT; j++) begin
      ev[j] = 1'b0;
      ed[j] = '0;
      ee[j] = 1'b0;
      et[j] = "none";
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_sel   = '0;
    bus.req_wdata = '0;
`ifdef DM_BANK_PARITY_EN
    bus.inj_par_err = 1'b0;
`endif

    // Reset two cycles, then the 16-cycle zero sweep.
    rst = 1'b1;
    idle(2);
    check("rst_busy", {31'b0, bus.busy_init}, 32'd1);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    wait_init();

    // Full write then read of the same word on the next cycle.
    wr("wr_beef", 32'h8, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0);
    rd("rd_beef", 32'h8, 4'b1111, 32'hDEADBEEF, 1'b0);
    idle(RD_LAT);

    // Partial write over a zeroed word; low address bits ignored.
    wr("wr_part", 32'h10, 4'b0101, 32'h11223344, 1'b0, 1'b0);
    rd("rd_part_all", 32'h10, 4'b1111, 32'h00220044, 1'b0);
    rd("rd_part_l0", 32'h13, 4'b0001, 32'h00000044, 1'b0);
    idle(RD_LAT);

    // Range and strobe errors; no array update, no aliasing.
    rd("rd_oor", 32'h40, 4'b1111, 32'h0, 1'b1);
    wr("wr_nosel", 32'h8, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b1);
    wr("wr_oor", 32'h40, 4'b1111, 32'h12345678, 1'b0, 1'b1);
    rd("rd_hi", 32'h80000000, 4'b1111, 32'h0, 1'b1);
    rd("rd_nosel", 32'h8, 4'b0000, 32'h0, 1'b1);
    rd("rd_keep", 32'h8, 4'b1111, 32'hDEADBEEF, 1'b0);
    rd("rd_noalias", 32'h0, 4'b1111, 32'h0, 1'b0);
    idle(RD_LAT);

    // Back-to-back burst, responses in order.
    wr("wr_cafe", 32'hC, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0);
    rd("b0", 32'h8, 4'b1111, 32'hDEADBEEF, 1'b0);
    rd("b1", 32'h10, 4'b1111, 32'h00220044, 1'b0);
    rd("b2", 32'hC, 4'b1111, 32'hCAFEF00D, 1'b0);
    rd("b3", 32'h0, 4'b0010, 32'h0, 1'b0);
    rd("b4", 32'hC, 4'b1000, 32'hCA000000, 1'b0);
    idle(RD_LAT + 1);

    // Reset mid-burst: in-flight responses dropped, memory re-zeroed.
    rd("m0", 32'h8, 4'b1111, 32'hDEADBEEF, 1'b0);
    rd("m1", 32'hC, 4'b1111, 32'hCAFEF00D, 1'b0);
    rd("m2", 32'h10, 4'b1111, 32'h00220044, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    wait_init();
    rd("rz_8", 32'h8, 4'b1111, 32'h0, 1'b0);
    rd("rz_c", 32'hC, 4'b1111, 32'h0, 1'b0);
    idle(RD_LAT);

`ifdef DM_BANK_PARITY_EN
    // Injected parity faults flagged on read with data returned.
    wr("p_wr_inj", 32'h14, 4'b1111, 32'hA5A5A5A5, 1'b1, 1'b0);
    rd("p_rd_bad", 32'h14, 4'b1111, 32'hA5A5A5A5, 1'b1);
    rd("p_rd_bad_l0", 32'h14, 4'b0001, 32'h000000A5, 1'b1);
    wr("p_wr_inj_lo", 32'h18, 4'b0011, 32'h00005A5A, 1'b1, 1'b0);
    rd("p_rd_hi_ok", 32'h18, 4'b1100, 32'h0, 1'b0);
    rd("p_rd_lo_bad", 32'h18, 4'b0011, 32'h00005A5A, 1'b1);
    wr("p_wr_clean", 32'h14, 4'b1111, 32'hA5A5A5A5, 1'b0, 1'b0);
    rd("p_rd_clean", 32'h14, 4'b1111, 32'hA5A5A5A5, 1'b0);
    idle(RD_LAT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
